segment_display_decoder: RTL

//   Receiving end of the priority-encoder display link: samples the 7-segment bus {none, segments[6:0]}.

---
 rtl/segment_display_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/segment_display_decoder.sv
// Receiving end of the 7-segment display link: synchronises and debounces {none, segments},
// decodes the pattern to a digit index / one-hot word and issues each new stable pattern over valid/ready.
module segment_display_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       segments,
    input  logic             none,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [2:0]       code,
    output logic [7:0]       data_onehot,
    output logic             no_data,
    output logic             illegal,
    output logic [CNT_W-1:0] event_count
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic [2:0] code;
        logic [7:0] onehot;
        logic       no_data;
        logic       illegal;
    } payload_t;

    function automatic payload_t decode_pattern(input logic [7:0] pat);
        payload_t p;
        p = '{code: 3'd0, onehot: 8'h00, no_data: 1'b0, illegal: 1'b0};
        case (pat)
            8'h3F:   begin p.code = 3'd0; p.onehot = 8'h01; end
            8'h06:   begin p.code = 3'd1; p.onehot = 8'h02; end
            8'h5B:   begin p.code = 3'd2; p.onehot = 8'h04; end
            8'h4F:   begin p.code = 3'd3; p.onehot = 8'h08; end
            8'h66:   begin p.code = 3'd4; p.onehot = 8'h10; end
            8'h6D:   begin p.code = 3'd5; p.onehot = 8'h20; end
            8'h7D:   begin p.code = 3'd6; p.onehot = 8'h40; end
            8'h07:   begin p.code = 3'd7; p.onehot = 8'h80; end
            8'h80:   begin p.no_data = 1'b1; end
            default: begin p.illegal = 1'b1; end
        endcase
        return p;
    endfunction

    logic [7:0]       sync1_q;
    logic [7:0]       samp_q;
    logic [SW-1:0]    stab_cnt_q, stab_cnt_d;
    logic [7:0]       last_pat_q, last_pat_d;
    logic [0:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    payload_t         payload_q, payload_d;
    logic [CNT_W-1:0] event_count_q, event_count_d;
    logic             qualified_s;

    // Two-stage synchroniser on the asynchronous display pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 8'h00;
            samp_q  <= 8'h00;
        end else begin
            sync1_q <= {none, segments};
            samp_q  <= sync1_q;
        end
    end

    // Run length of identical samples; sync1_q is the sample samp_q takes next.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (sync1_q != samp_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_MAX) begin
            stab_cnt_d = stab_cnt_q;
        end else begin
            stab_cnt_d = stab_cnt_q + SW'(1);
        end
    end

    assign qualified_s = (stab_cnt_q == STAB_MAX) && (samp_q != last_pat_q);

    // Handshake FSM: capture a qualified pattern in WAIT, hold it until accepted.
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        payload_d     = payload_q;
        last_pat_d    = last_pat_q;
        event_count_d = event_count_q;
        case (state_q)
            ST_WAIT: begin
                if (qualified_s) begin
                    payload_d   = decode_pattern(samp_q);
                    last_pat_d  = samp_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d   = 1'b0;
                    event_count_d = event_count_q + CNT_W'(1);
                    state_d       = ST_WAIT;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_WAIT;
            end
        endcase
    end

    // Stability counter, FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt_q    <= '0;
            last_pat_q    <= 8'h00;
            state_q       <= ST_WAIT;
            out_valid_q   <= 1'b0;
            payload_q     <= '0;
            event_count_q <= '0;
        end else begin
            stab_cnt_q    <= stab_cnt_d;
            last_pat_q    <= last_pat_d;
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            payload_q     <= payload_d;
            event_count_q <= event_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign code        = payload_q.code;
    assign data_onehot = payload_q.onehot;
    assign no_data     = payload_q.no_data;
    assign illegal     = payload_q.illegal;
    assign event_count = event_count_q;

endmodule
